// File: rtl/uart_fifo_duplex.sv
`timescale 1ns/1ps
// Full-duplex UART with parametrised framing and an RX FIFO that keeps
// per-word parity/framing flags plus a sticky overrun flag.
//
// TX state   | meaning
// TX_IDLE    | line high, ready for a word
// TX_START   | driving the start bit
// TX_DATA    | shifting data out, LSB first
// TX_PARITY  | driving the parity bit
// TX_STOP    | driving STOP_BITS stop bits
//
// RX state     | meaning
// RX_IDLE      | waiting for a falling edge on rxs
// RX_START     | half-bit wait, then confirm the start bit
// RX_DATA      | sampling data bits mid-bit, LSB first
// RX_PARITY    | sampling and checking the parity bit
// RX_STOP      | sampling the stop bit; word is pushed here
// RX_WAIT_HIGH | framing error seen; hold off until the line returns high
module uart_fifo_duplex #(
  parameter int CLK_HZ    = 50_000_000,
  parameter int BAUD      = 9600,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1,
  parameter int RX_DEPTH  = 8
) (
  input  logic                        clk,
  input  logic                        n_rst,
  input  logic [DATA_BITS-1:0]        tx_data,
  input  logic                        tx_send,
  output logic                        tx_ready,
  output logic                        tx,
  input  logic                        rx,
  input  logic                        rx_pop,
  output logic [DATA_BITS-1:0]        rx_data,
  output logic                        rx_valid,
  output logic                        rx_parity_err,
  output logic                        rx_frame_err,
  output logic [$clog2(RX_DEPTH):0]   rx_count,
  output logic                        rx_overrun,
  input  logic                        err_clr,
  output logic                        uart_busy
);

  localparam int   BIT_TICKS  = CLK_HZ / BAUD;
  localparam int   HALF_TICKS = BIT_TICKS / 2;
  localparam int   STOP_TICKS = STOP_BITS * BIT_TICKS;
  localparam int   CNT_W      = $clog2(STOP_TICKS + 1);
  localparam int   AW         = $clog2(RX_DEPTH);
  localparam int   CW         = AW + 1;
  localparam int   ENTRY_W    = DATA_BITS + 2;
  localparam logic HAS_PARITY = (PARITY != 0);
  localparam logic ODD_PARITY = (PARITY == 2);

  typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_t;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP, RX_WAIT_HIGH} rx_state_t;

  tx_state_t            tx_state;
  logic [CNT_W-1:0]     tx_cnt;
  logic [3:0]           tx_bit;
  logic [DATA_BITS-1:0] tx_shift;
  logic                 tx_par;

  rx_state_t            rx_state;
  logic                 rx_meta;
  logic                 rxs;
  logic [CNT_W-1:0]     rx_cnt;
  logic [3:0]           rx_bit;
  logic [DATA_BITS-1:0] rx_shift;
  logic                 rx_perr;

  logic [ENTRY_W-1:0]   mem [RX_DEPTH];
  logic [AW-1:0]        wr_ptr;
  logic [AW-1:0]        rd_ptr;
  logic [CW-1:0]        count;
  logic [ENTRY_W-1:0]   head;
  logic [ENTRY_W-1:0]   push_entry;
  logic                 rx_push;
  logic                 do_push;
  logic                 do_pop;
  logic                 drop;

  // TX frame sequencer: each bit held BIT_TICKS cycles via a down-counter
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      tx_state <= TX_IDLE;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_shift <= '0;
      tx_par   <= 1'b0;
      tx       <= 1'b1;
      tx_ready <= 1'b1;
    end else begin
      case (tx_state)
        TX_IDLE: begin
          if (tx_send) begin
            tx_state <= TX_START;
            tx_shift <= tx_data;
            tx_par   <= (^tx_data) ^ ODD_PARITY;
            tx_cnt   <= CNT_W'(BIT_TICKS - 1);
            tx       <= 1'b0;
            tx_ready <= 1'b0;
          end
        end
        TX_START: begin
          if (tx_cnt == '0) begin
            tx_state <= TX_DATA;
            tx       <= tx_shift[0];
            tx_shift <= tx_shift >> 1;
            tx_bit   <= '0;
            tx_cnt   <= CNT_W'(BIT_TICKS - 1);
          end else begin
            tx_cnt <= tx_cnt - 1'b1;
          end
        end
        TX_DATA: begin
          if (tx_cnt == '0) begin
            if (tx_bit == 4'(DATA_BITS - 1)) begin
              if (HAS_PARITY) begin
                tx_state <= TX_PARITY;
                tx       <= tx_par;
                tx_cnt   <= CNT_W'(BIT_TICKS - 1);
              end else begin
                tx_state <= TX_STOP;
                tx       <= 1'b1;
                tx_cnt   <= CNT_W'(STOP_TICKS - 1);
              end
            end else begin
              tx       <= tx_shift[0];
              tx_shift <= tx_shift >> 1;
              tx_bit   <= tx_bit + 1'b1;
              tx_cnt   <= CNT_W'(BIT_TICKS - 1);
            end
          end else begin
            tx_cnt <= tx_cnt - 1'b1;
          end
        end
        TX_PARITY: begin
          if (tx_cnt == '0) begin
            tx_state <= TX_STOP;
            tx       <= 1'b1;
            tx_cnt   <= CNT_W'(STOP_TICKS - 1);
          end else begin
            tx_cnt <= tx_cnt - 1'b1;
          end
        end
        TX_STOP: begin
          if (tx_cnt == '0) begin
            tx_state <= TX_IDLE;
            tx_ready <= 1'b1;
          end else begin
            tx_cnt <= tx_cnt - 1'b1;
          end
        end
        default: begin
          tx_state <= TX_IDLE;
          tx       <= 1'b1;
          tx_ready <= 1'b1;
        end
      endcase
    end
  end

  // Two-flop synchroniser for the asynchronous rx pin; idles high
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= rx;
      rxs     <= rx_meta;
    end
  end

  // RX frame sampler: mid-bit sampling referenced to the confirmed start bit
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      rx_state <= RX_IDLE;
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_shift <= '0;
      rx_perr  <= 1'b0;
    end else begin
      case (rx_state)
        RX_IDLE: begin
          if (!rxs) begin
            rx_state <= RX_START;
            rx_cnt   <= CNT_W'(HALF_TICKS - 1);
          end
        end
        RX_START: begin
          if (rx_cnt == '0) begin
            if (rxs) begin
              rx_state <= RX_IDLE;
            end else begin
              rx_state <= RX_DATA;
              rx_bit   <= '0;
              rx_perr  <= 1'b0;
              rx_cnt   <= CNT_W'(BIT_TICKS - 1);
            end
          end else begin
            rx_cnt <= rx_cnt - 1'b1;
          end
        end
        RX_DATA: begin
          if (rx_cnt == '0) begin
            rx_shift <= {rxs, rx_shift[DATA_BITS-1:1]};
            rx_cnt   <= CNT_W'(BIT_TICKS - 1);
            if (rx_bit == 4'(DATA_BITS - 1)) begin
              rx_state <= HAS_PARITY ? RX_PARITY : RX_STOP;
            end else begin
              rx_bit <= rx_bit + 1'b1;
            end
          end else begin
            rx_cnt <= rx_cnt - 1'b1;
          end
        end
        RX_PARITY: begin
          if (rx_cnt == '0) begin
            rx_perr  <= rxs ^ (^rx_shift) ^ ODD_PARITY;
            rx_state <= RX_STOP;
            rx_cnt   <= CNT_W'(BIT_TICKS - 1);
          end else begin
            rx_cnt <= rx_cnt - 1'b1;
          end
        end
        RX_STOP: begin
          if (rx_cnt == '0) begin
            rx_state <= rxs ? RX_IDLE : RX_WAIT_HIGH;
          end else begin
            rx_cnt <= rx_cnt - 1'b1;
          end
        end
        RX_WAIT_HIGH: begin
          if (rxs) rx_state <= RX_IDLE;
        end
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

  assign rx_push    = (rx_state == RX_STOP) && (rx_cnt == '0);
  assign push_entry = {~rxs, rx_perr, rx_shift};
  assign do_pop     = rx_pop && (count != '0);
  assign do_push    = rx_push && ((count != CW'(RX_DEPTH)) || do_pop);
  assign drop       = rx_push && !do_push;

  // FIFO storage; a pop at full frees the slot that the same-cycle push reuses
  always_ff @(posedge clk) begin
    if (n_rst && do_push) mem[wr_ptr] <= push_entry;
  end

  // FIFO pointers, occupancy and sticky overrun (set beats clear)
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      rx_overrun <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (do_pop && !do_push) count <= count - 1'b1;
      if (drop)         rx_overrun <= 1'b1;
      else if (err_clr) rx_overrun <= 1'b0;
    end
  end

  assign head          = mem[rd_ptr];
  assign rx_valid      = (count != '0);
  assign rx_data       = rx_valid ? head[DATA_BITS-1:0] : '0;
  assign rx_parity_err = rx_valid & head[DATA_BITS];
  assign rx_frame_err  = rx_valid & head[DATA_BITS+1];
  assign rx_count      = count;
  assign uart_busy     = (tx_state != TX_IDLE) || (rx_state != RX_IDLE);

endmodule

// File: tb/tb_uart_fifo_duplex.sv
`timescale 1ns/1ps
// Directed bench for uart_fifo_duplex at BIT_TICKS=10.
// dut_a: 8N1, depth 4 (TX timing, glitch, overrun, reset)
// dut_b: even parity, rx looped back from tx
// dut_c: odd parity, rx driven by the bench (parity and framing errors)
module tb_uart_fifo_duplex;

  logic clk = 1'b0;
  logic n_rst = 1'b0;

  logic [7:0] tx_data_a = '0, tx_data_b = '0, tx_data_c = '0;
  logic       tx_send_a = 0, tx_send_b = 0, tx_send_c = 0;
  logic       tx_ready_a, tx_ready_b, tx_ready_c;
  logic       tx_a, tx_b, tx_c;
  logic       rx_a = 1'b1, rx_c = 1'b1;
  logic       rx_pop_a = 0, rx_pop_b = 0, rx_pop_c = 0;
  logic [7:0] rx_data_a, rx_data_b, rx_data_c;
  logic       rx_valid_a, rx_valid_b, rx_valid_c;
  logic       perr_a, perr_b, perr_c;
  logic       ferr_a, ferr_b, ferr_c;
  logic [2:0] rx_count_a;
  logic [3:0] rx_count_b, rx_count_c;
  logic       ovr_a, ovr_b, ovr_c;
  logic       err_clr_a = 0, err_clr_b = 0, err_clr_c = 0;
  logic       busy_a, busy_b, busy_c;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  uart_fifo_duplex #(.CLK_HZ(1_000_000), .BAUD(100_000), .DATA_BITS(8), .PARITY(0),
                     .STOP_BITS(1), .RX_DEPTH(4)) dut_a (
    .clk(clk), .n_rst(n_rst), .tx_data(tx_data_a), .tx_send(tx_send_a),
    .tx_ready(tx_ready_a), .tx(tx_a), .rx(rx_a), .rx_pop(rx_pop_a),
    .rx_data(rx_data_a), .rx_valid(rx_valid_a), .rx_parity_err(perr_a),
    .rx_frame_err(ferr_a), .rx_count(rx_count_a), .rx_overrun(ovr_a),
    .err_clr(err_clr_a), .uart_busy(busy_a));

  uart_fifo_duplex #(.CLK_HZ(1_000_000), .BAUD(100_000), .DATA_BITS(8), .PARITY(1),
                     .STOP_BITS(1), .RX_DEPTH(8)) dut_b (
    .clk(clk), .n_rst(n_rst), .tx_data(tx_data_b), .tx_send(tx_send_b),
    .tx_ready(tx_ready_b), .tx(tx_b), .rx(tx_b), .rx_pop(rx_pop_b),
    .rx_data(rx_data_b), .rx_valid(rx_valid_b), .rx_parity_err(perr_b),
    .rx_frame_err(ferr_b), .rx_count(rx_count_b), .rx_overrun(ovr_b),
    .err_clr(err_clr_b), .uart_busy(busy_b));

  uart_fifo_duplex #(.CLK_HZ(1_000_000), .BAUD(100_000), .DATA_BITS(8), .PARITY(2),
                     .STOP_BITS(1), .RX_DEPTH(8)) dut_c (
    .clk(clk), .n_rst(n_rst), .tx_data(tx_data_c), .tx_send(tx_send_c),
    .tx_ready(tx_ready_c), .tx(tx_c), .rx(rx_c), .rx_pop(rx_pop_c),
    .rx_data(rx_data_c), .rx_valid(rx_valid_c), .rx_parity_err(perr_c),
    .rx_frame_err(ferr_c), .rx_count(rx_count_c), .rx_overrun(ovr_c),
    .err_clr(err_clr_c), .uart_busy(busy_c));

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // sel 0 drives dut_a's rx, anything else dut_c's; called on a falling edge
  task automatic drive_rx(input int sel, input logic v, input int n);
    if (sel == 0) rx_a = v;
    else          rx_c = v;
    repeat (n) @(negedge clk);
  endtask

  // pop_stop asserts rx_pop_a for exactly the stop-sample edge (7 ticks into stop)
  task automatic drive_frame(input int sel, input logic [7:0] d, input logic has_par,
                             input logic par_bit, input logic stop_bit, input logic pop_stop);
    drive_rx(sel, 1'b0, 10);
    for (int i = 0; i < 8; i++) drive_rx(sel, d[i], 10);
    if (has_par) drive_rx(sel, par_bit, 10);
    if (pop_stop) begin
      drive_rx(sel, stop_bit, 7);
      rx_pop_a = 1'b1;
      @(negedge clk);
      rx_pop_a = 1'b0;
      repeat (2) @(negedge clk);
    end else begin
      drive_rx(sel, stop_bit, 10);
    end
  endtask

  task automatic pop(input int sel);
    if (sel == 0)      rx_pop_a = 1'b1;
    else if (sel == 1) rx_pop_b = 1'b1;
    else               rx_pop_c = 1'b1;
    @(negedge clk);
    rx_pop_a = 1'b0;
    rx_pop_b = 1'b0;
    rx_pop_c = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [7:0] pat;
    logic       exp_tx;
    logic [7:0] exp_word;
    int         k;

    // reset
    repeat (3) @(negedge clk);
    n_rst = 1'b1;
    @(negedge clk);
    check_val("rst_tx", tx_a, 1);
    check_val("rst_tx_ready", tx_ready_a, 1);
    check_val("rst_rx_valid", rx_valid_a, 0);
    check_val("rst_rx_count", rx_count_a, 0);
    check_val("rst_overrun", ovr_a, 0);
    check_val("rst_busy", busy_a, 0);
    check_val("rst_tx_b", tx_b, 1);
    check_val("rst_tx_c", tx_c, 1);

    // TX 8N1 0xA5 accepted at edge 0; cycle c is the period after edge c-1
    pat = 8'hA5;
    tx_data_a = pat;
    tx_send_a = 1'b1;
    @(negedge clk);
    tx_send_a = 1'b0;
    for (int c = 1; c <= 101; c++) begin
      if (c <= 10)      exp_tx = 1'b0;
      else if (c <= 90) exp_tx = pat[(c - 11) / 10];
      else              exp_tx = 1'b1;
      check_val($sformatf("tx_bit_c%0d", c), tx_a, exp_tx);
      if (c == 1 || c == 100) check_val($sformatf("tx_ready_c%0d", c), tx_ready_a, 0);
      if (c == 50) check_val("tx_busy", busy_a, 1);
      if (c == 101) begin
        check_val("tx_ready_done", tx_ready_a, 1);
        check_val("tx_busy_done", busy_a, 0);
      end
      if (c == 5) begin
        tx_send_a = 1'b1;
        tx_data_a = 8'hFF;
      end
      if (c == 6) tx_send_a = 1'b0;
      if (c < 101) @(negedge clk);
    end

    // loopback, even parity, 0x3C
    tx_data_b = 8'h3C;
    tx_send_b = 1'b1;
    @(negedge clk);
    tx_send_b = 1'b0;
    k = 0;
    while (!rx_valid_b && k < 400) begin
      @(negedge clk);
      k++;
    end
    check_val("lb_valid", rx_valid_b, 1);
    check_val("lb_data", rx_data_b, 8'h3C);
    check_val("lb_perr", perr_b, 0);
    check_val("lb_ferr", ferr_b, 0);
    check_val("lb_count", rx_count_b, 1);
    pop(1);
    check_val("lb_pop_valid", rx_valid_b, 0);
    check_val("lb_pop_data", rx_data_b, 0);

    // odd parity: 0x01 needs parity 0, send 1
    drive_frame(1, 8'h01, 1'b1, 1'b1, 1'b1, 1'b0);
    drive_rx(1, 1'b1, 5);
    check_val("par_valid", rx_valid_c, 1);
    check_val("par_data", rx_data_c, 8'h01);
    check_val("par_perr", perr_c, 1);
    check_val("par_ferr", ferr_c, 0);
    pop(2);
    // 0x5A with correct odd parity (1), stop bit 0, line held low 50 cycles
    drive_frame(1, 8'h5A, 1'b1, 1'b1, 1'b0, 1'b0);
    drive_rx(1, 1'b0, 40);
    check_val("frm_count", rx_count_c, 1);
    check_val("frm_data", rx_data_c, 8'h5A);
    check_val("frm_ferr", ferr_c, 1);
    check_val("frm_perr", perr_c, 0);
    check_val("frm_busy_low", busy_c, 1);
    drive_rx(1, 1'b1, 20);
    check_val("frm_count_after", rx_count_c, 1);
    check_val("frm_busy_high", busy_c, 0);

    // 3-cycle glitch on dut_a
    drive_rx(0, 1'b0, 3);
    check_val("glitch_busy", busy_a, 1);
    drive_rx(0, 1'b1, 15);
    check_val("glitch_valid", rx_valid_a, 0);
    check_val("glitch_count", rx_count_a, 0);
    check_val("glitch_idle", busy_a, 0);

    // overrun: five words into a depth-4 FIFO
    for (int i = 1; i <= 5; i++) begin
      exp_word = 8'(i * 8'h11);
      drive_frame(0, exp_word, 1'b0, 1'b0, 1'b1, 1'b0);
    end
    check_val("ovr_count", rx_count_a, 4);
    check_val("ovr_flag", ovr_a, 1);
    for (int i = 1; i <= 4; i++) begin
      exp_word = 8'(i * 8'h11);
      check_val($sformatf("ovr_pop%0d", i), rx_data_a, exp_word);
      pop(0);
    end
    check_val("ovr_empty", rx_valid_a, 0);
    check_val("ovr_sticky", ovr_a, 1);
    err_clr_a = 1'b1;
    @(negedge clk);
    err_clr_a = 1'b0;
    check_val("ovr_clr", ovr_a, 0);

    // refill, then push+pop in the same cycle at full
    for (int i = 6; i <= 9; i++) begin
      exp_word = 8'(i * 8'h11);
      drive_frame(0, exp_word, 1'b0, 1'b0, 1'b1, 1'b0);
    end
    check_val("full_count", rx_count_a, 4);
    drive_frame(0, 8'hAA, 1'b0, 1'b0, 1'b1, 1'b1);
    check_val("pp_count", rx_count_a, 4);
    check_val("pp_no_ovr", ovr_a, 0);
    check_val("pp_head", rx_data_a, 8'h77);
    repeat (3) pop(0);
    check_val("pp_tail", rx_data_a, 8'hAA);

    // reset mid-frame: TX 0x07 with a partial RX frame alongside
    tx_data_a = 8'h07;
    tx_send_a = 1'b1;
    rx_a = 1'b0;
    @(negedge clk);
    tx_send_a = 1'b0;
    repeat (24) @(negedge clk);
    rx_a = 1'b1;
    repeat (18) @(negedge clk);
    check_val("pre_rst_tx", tx_a, 0);
    check_val("pre_rst_ready", tx_ready_a, 0);
    check_val("pre_rst_busy", busy_a, 1);
    n_rst = 1'b0;
    @(negedge clk);
    n_rst = 1'b1;
    check_val("mid_rst_tx", tx_a, 1);
    check_val("mid_rst_ready", tx_ready_a, 1);
    check_val("mid_rst_count", rx_count_a, 0);
    check_val("mid_rst_busy", busy_a, 0);
    check_val("mid_rst_count_c", rx_count_c, 0);
    repeat (150) @(negedge clk);
    check_val("post_rst_count", rx_count_a, 0);
    check_val("post_rst_valid", rx_valid_a, 0);
    check_val("post_rst_tx", tx_a, 1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
